lfsr_tpg: RTL and testbench

Parametrised LFSR test-pattern generator for the LBIST TPG. It generalises the fixed-width free-running LFSR with a selectable polynomial table covering 7/16/19/20/24/32 bits, runtime seed loading, and a programmable pattern count. It also adds a start/busy/done handshake toward the LBIST controller and lockup-state protection. It drives scan-chain inputs or a phase shifter and provides one pattern per valid cycle.

---
 rtl/lfsr_tpg_if.sv | 28 ++
 rtl/lfsr_tpg.sv | 120 ++++++++++++
 tb/tb_lfsr_tpg.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_tpg_if.sv
// Control/status bundle between the LBIST controller and the LFSR pattern generator.
// The controller side is the master; the generator side is the slave.
interface lfsr_tpg_if #(
  parameter int N     = 20,
  parameter int CNT_W = 16
);
  logic             start;
  logic             seed_load;
  logic [N-1:0]     seed_in;
  logic [CNT_W-1:0] num_patterns;
  logic             pause;
  logic [N-1:0]     dout;
  logic             dout_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pat_idx;
  logic             lockup_err;

  modport master (
    output start, seed_load, seed_in, num_patterns, pause,
    input  dout, dout_valid, busy, done, pat_idx, lockup_err
  );

  modport slave (
    input  start, seed_load, seed_in, num_patterns, pause,
    output dout, dout_valid, busy, done, pat_idx, lockup_err
  );
endinterface

// File: rtl/lfsr_tpg.sv
// Fibonacci XNOR LFSR test-pattern generator with seed loading, a programmable
// pattern count, a start/busy/done handshake and all-ones lockup protection.
module lfsr_tpg #(
  parameter int             N     = 20,
  parameter logic [N-1:0]   SEED  = {{(N-1){1'b0}}, 1'b1},
  parameter int             CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_tpg_if.slave  bus
);

  // Maximal-length XNOR tap sets, one bit per tapped dout index.
  localparam logic [31:0] TAP_TABLE =
    (N == 7)  ? 32'h0000_0011 :
    (N == 16) ? 32'h0000_100B :
    (N == 19) ? 32'h0006_4001 :
    (N == 20) ? 32'h0002_0001 :
    (N == 24) ? 32'h00C2_0001 :
    (N == 32) ? 32'hC000_0401 : 32'h0000_0000;

  localparam logic [N-1:0]     TAPS    = TAP_TABLE[N-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  generate
    if (TAP_TABLE == 32'h0) begin : g_bad_width
      $error("lfsr_tpg: unsupported LFSR width N=%0d", N);
    end
    if (SEED == {N{1'b1}}) begin : g_bad_seed
      $error("lfsr_tpg: SEED must not be the all-ones lockup state");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [N-1:0]     r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_idx;
  logic             r_lockup;

  state_t           w_state_nxt;
  logic [N-1:0]     w_lfsr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_lockup_nxt;

  logic [N-1:0]     w_lfsr_step;
  logic             w_seed_bad;
  logic [N-1:0]     w_seed_val;
  logic             w_last;

  assign w_lfsr_step = {~(^(r_lfsr & TAPS)), r_lfsr[N-1:1]};
  assign w_seed_bad  = &bus.seed_in;
  assign w_seed_val  = w_seed_bad ? SEED : bus.seed_in;
  assign w_last      = (r_idx == (r_cnt - CNT_ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr   <= SEED;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_lockup <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_lockup <= w_lockup_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_lockup_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        // A same-cycle seed_load wins the LFSR, so a start in that cycle runs from the new seed.
        if (bus.seed_load) begin
          w_lfsr_nxt   = w_seed_val;
          w_lockup_nxt = w_seed_bad;
        end
        if (bus.start) begin
          w_cnt_nxt   = bus.num_patterns;
          w_idx_nxt   = '0;
          w_state_nxt = (bus.num_patterns != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (!bus.pause) begin
          w_lfsr_nxt = w_lfsr_step;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.dout       = r_lfsr;
  assign bus.dout_valid = (r_state == S_RUN) && !bus.pause;
  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.pat_idx    = r_idx;
  assign bus.lockup_err = r_lockup;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Scoreboard bench for lfsr_tpg: a tap-list reference model queues expected
// patterns at each start; a negedge monitor checks every valid pattern.
module tb_lfsr_tpg;

  logic clk = 1'b0;
  logic rst;
  logic rst24;

  always #5 clk = ~clk;

  lfsr_tpg_if #(.N(7),  .CNT_W(16)) b7 ();
  lfsr_tpg_if #(.N(20), .CNT_W(16)) b20 ();
  lfsr_tpg_if #(.N(24), .CNT_W(16)) b24 ();

  lfsr_tpg #(.N(7),  .SEED(7'h01),     .CNT_W(16)) u7  (.clk(clk), .rst(rst),   .bus(b7));
  lfsr_tpg #(.N(20), .SEED(20'h00001), .CNT_W(16)) u20 (.clk(clk), .rst(rst),   .bus(b20));
  lfsr_tpg #(.N(24), .SEED(24'h000001),.CNT_W(16)) u24 (.clk(clk), .rst(rst24), .bus(b24));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] d;
    int         idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [6:0] obs[$];
  logic [6:0] m7;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference step: feedback is the inverted XOR of the tapped bits, shifted in at the MSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input int n);
    int          taps[$];
    bit          x;
    logic [31:0] r;
    case (n)
      7:       taps = '{0, 4};
      16:      taps = '{0, 1, 3, 12};
      19:      taps = '{0, 14, 17, 18};
      20:      taps = '{0, 17};
      24:      taps = '{0, 17, 22, 23};
      default: taps = '{0, 10, 30, 31};
    endcase
    x = 1'b0;
    foreach (taps[i]) x ^= s[taps[i]];
    r = s >> 1;
    r[n-1] = ~x;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && b7.dout_valid) begin
      obs.push_back(b7.dout);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual=0x%0h expected=no_pattern", b7.dout);
      end else begin
        e = exp_q.pop_front();
        check("sb_dout", 64'(b7.dout), 64'(e.d));
        check("sb_pat_idx", 64'(b7.pat_idx), 64'(e.idx));
      end
    end
  end

  // Called at posedge+1 with the N=7 DUT in IDLE or DONE.
  task automatic run7(input int n, input bit ld, input logic [6:0] sd, input int pct,
                      input int pause_at, input int pause_len);
    int          cyc;
    bit          paused;
    logic [6:0]  hold_d;
    logic [15:0] hold_i;
    logic [31:0] tmp;
    obs.delete();
    b7.start        = 1'b1;
    b7.num_patterns = n[15:0];
    b7.seed_load    = ld;
    b7.seed_in      = sd;
    b7.pause        = 1'b0;
    if (ld) m7 = (sd == 7'h7F) ? 7'h01 : sd;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_t'{d: m7, idx: i});
      tmp = lfsr_next({25'd0, m7}, 7);
      m7  = tmp[6:0];
    end
    @(posedge clk); #1;
    b7.start     = 1'b0;
    b7.seed_load = 1'b0;
    if (ld) check("lockup_err", 64'(b7.lockup_err), 64'(sd == 7'h7F));
    cyc    = 0;
    paused = 1'b0;
    while (!b7.done && cyc < 8 * n + 64) begin
      if (pause_at >= 0 && !paused && b7.busy && b7.pat_idx == pause_at[15:0]) begin
        paused   = 1'b1;
        hold_d   = b7.dout;
        hold_i   = b7.pat_idx;
        b7.pause = 1'b1;
        repeat (pause_len) begin
          @(negedge clk);
          check("pause_valid", 64'(b7.dout_valid), 64'd0);
          check("pause_dout", 64'(b7.dout), 64'(hold_d));
          check("pause_idx", 64'(b7.pat_idx), 64'(hold_i));
          @(posedge clk); #1;
          cyc++;
        end
        b7.pause = 1'b0;
      end else begin
        b7.pause = (pct > 0) && ($urandom_range(99) < pct);
        @(posedge clk); #1;
        cyc++;
      end
    end
    b7.pause = 1'b0;
    check("run_done", 64'(b7.done), 64'd1);
    check("run_busy", 64'(b7.busy), 64'd0);
    check("run_valid_low", 64'(b7.dout_valid), 64'd0);
    check("run_final_lfsr", 64'(b7.dout), 64'(m7));
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("run_valid_count", 64'(obs.size()), 64'(n));
    exp_q.delete();
  endtask

  initial begin
    logic [6:0] tbl [6];
    bit         seen [128];
    int         uniq;
    int         cyc;
    tbl = '{7'h01, 7'h00, 7'h40, 7'h60, 7'h70, 7'h38};

    rst   = 1'b1;
    rst24 = 1'b1;
    b7.start = 1'b0;  b7.seed_load = 1'b0;  b7.seed_in = '0;  b7.num_patterns = '0;  b7.pause = 1'b0;
    b20.start = 1'b0; b20.seed_load = 1'b0; b20.seed_in = '0; b20.num_patterns = '0; b20.pause = 1'b0;
    b24.start = 1'b0; b24.seed_load = 1'b0; b24.seed_in = '0; b24.num_patterns = '0; b24.pause = 1'b0;
    m7 = 7'h01;

    // Reset and idle
    repeat (2) begin @(posedge clk); #1; end
    check("rst_dout", 64'(b7.dout), 64'h01);
    check("rst_valid", 64'(b7.dout_valid), 64'd0);
    check("rst_busy", 64'(b7.busy), 64'd0);
    check("rst_done", 64'(b7.done), 64'd0);
    check("rst_pat_idx", 64'(b7.pat_idx), 64'd0);
    check("rst_lockup", 64'(b7.lockup_err), 64'd0);
    rst   = 1'b0;
    rst24 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("idle_dout", 64'(b7.dout), 64'h01);
    check("idle_valid", 64'(b7.dout_valid), 64'd0);

    // Basic sequence against the known first six patterns
    run7(6, 1'b0, 7'h00, 0, -1, 0);
    for (int i = 0; i < 6; i++)
      check("basic_seq", (i < obs.size()) ? 64'(obs[i]) : 64'hDEAD, 64'(tbl[i]));

    // Pause in the middle of a run
    run7(4, 1'b0, 7'h00, 0, 1, 3);

    // All-ones seed rejected on the N=7 instance
    run7(3, 1'b1, 7'h7F, 0, -1, 0);
    check("lockup_first_pat", (obs.size() > 0) ? 64'(obs[0]) : 64'hDEAD, 64'h01);
    check("lockup_err_cleared", 64'(b7.lockup_err), 64'd0);

    // Full period from seed 0x01
    run7(127, 1'b1, 7'h01, 0, -1, 0);
    foreach (seen[i]) seen[i] = 1'b0;
    uniq = 0;
    foreach (obs[i]) begin
      if (!seen[obs[i]]) uniq++;
      seen[obs[i]] = 1'b1;
    end
    check("period_distinct", 64'(uniq), 64'd127);
    check("period_no_all_ones", 64'(seen[127]), 64'd0);
    check("period_wrap", 64'(b7.dout), 64'h01);

    // Zero-length run
    run7(0, 1'b1, 7'h01, 0, -1, 0);

    // Randomised runs with random pause and occasional reseed
    for (int r = 0; r < 8; r++)
      run7(int'($urandom_range(40, 1)), bit'($urandom_range(1)), 7'($urandom_range(127)), 30, -1, 0);

    // N=20 seed handling
    b20.seed_load = 1'b1;
    b20.seed_in   = 20'hFFFFF;
    @(posedge clk); #1;
    b20.seed_load = 1'b0;
    check("n20_reject_dout", 64'(b20.dout), 64'h00001);
    check("n20_lockup_pulse", 64'(b20.lockup_err), 64'd1);
    @(posedge clk); #1;
    check("n20_lockup_end", 64'(b20.lockup_err), 64'd0);
    b20.seed_load    = 1'b1;
    b20.seed_in      = 20'h12345;
    b20.start        = 1'b1;
    b20.num_patterns = 16'd1;
    @(posedge clk); #1;
    b20.seed_load = 1'b0;
    b20.start     = 1'b0;
    check("n20_valid", 64'(b20.dout_valid), 64'd1);
    check("n20_dout", 64'(b20.dout), 64'h12345);
    check("n20_pat_idx", 64'(b20.pat_idx), 64'd0);
    @(posedge clk); #1;
    check("n20_done", 64'(b20.done), 64'd1);
    check("n20_valid_end", 64'(b20.dout_valid), 64'd0);

    // N=24 reset in the middle of a run
    b24.start        = 1'b1;
    b24.num_patterns = 16'd50;
    @(posedge clk); #1;
    b24.start = 1'b0;
    cyc = 0;
    while (b24.pat_idx != 16'd10 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("n24_reach_idx10", 64'(b24.pat_idx), 64'd10);
    rst24 = 1'b1;
    @(posedge clk); #1;
    check("n24_rst_dout", 64'(b24.dout), 64'h000001);
    check("n24_rst_valid", 64'(b24.dout_valid), 64'd0);
    check("n24_rst_busy", 64'(b24.busy), 64'd0);
    check("n24_rst_done", 64'(b24.done), 64'd0);
    check("n24_rst_idx", 64'(b24.pat_idx), 64'd0);
    rst24 = 1'b0;
    @(posedge clk); #1;
    check("n24_no_done", 64'(b24.done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
